// File: rtl/alu_32bit.sv
// rtl/alu_32bit.sv - registered 32-bit ALU with carry/overflow/zero/negative flags
//
// Samples A, B and ALUControl on every rising clk edge and presents the
// result and flags one edge later. There is no handshake and no state
// beyond the output registers.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (Result=0, Zero=1, others 0)
//   A, B       32-bit operands (unsigned unless the op says otherwise)
//   ALUControl 4-bit operation select
//   Result     registered 32-bit result
//   Carry      carry-out of ADD/SUB, 0 otherwise
//   OverFlow   signed overflow of ADD/SUB, 0 otherwise
//   Zero       Result == 0
//   Negative   Result[31]

module alu_32bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALUControl,
    output logic [31:0] Result,
    output logic        Carry,
    output logic        OverFlow,
    output logic        Zero,
    output logic        Negative
);

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_AND     = 4'b0010;
    localparam logic [3:0] OP_OR      = 4'b0011;
    localparam logic [3:0] OP_MUL     = 4'b0100;
    localparam logic [3:0] OP_DIV     = 4'b0101;
    localparam logic [3:0] OP_SRL     = 4'b0110;
    localparam logic [3:0] OP_SLL     = 4'b0111;
    localparam logic [3:0] OP_LTU     = 4'b1000;
    localparam logic [3:0] OP_SUMSIGN = 4'b1001;
    localparam logic [3:0] OP_REM     = 4'b1010;

    // 33-bit sums so bit 32 is the carry-out directly.
    logic [32:0] sum_ext;
    logic [32:0] diff_ext;
    logic [31:0] prod_lo;
    logic [31:0] quot;
    logic [31:0] remd;
    logic        b_is_zero;

    logic [31:0] next_result;
    logic        next_carry;
    logic        next_overflow;

    always_comb begin
        sum_ext   = {1'b0, A} + {1'b0, B};
        // Subtract as A + ~B + 1 so Carry=1 means "no borrow".
        diff_ext  = {1'b0, A} + {1'b0, ~B} + 33'd1;
        prod_lo   = A * B;
        b_is_zero = (B == 32'd0);
        // Divide-by-zero results are defined values, never X: the divider
        // output is not used when B is zero.
        quot      = b_is_zero ? 32'hFFFF_FFFF : (A / B);
        remd      = b_is_zero ? A : (A % B);
    end

    always_comb begin
        next_result   = 32'd0;
        next_carry    = 1'b0;
        next_overflow = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                next_result   = sum_ext[31:0];
                next_carry    = sum_ext[32];
                next_overflow = (A[31] == B[31]) && (sum_ext[31] != A[31]);
            end
            OP_SUB: begin
                next_result   = diff_ext[31:0];
                next_carry    = diff_ext[32];
                next_overflow = (A[31] != B[31]) && (diff_ext[31] != A[31]);
            end
            OP_AND:     next_result = A & B;
            OP_OR:      next_result = A | B;
            OP_MUL:     next_result = prod_lo;
            OP_DIV:     next_result = quot;
            OP_REM:     next_result = remd;
            OP_SRL:     next_result = {1'b0, A[31:1]};
            OP_SLL:     next_result = {A[30:0], 1'b0};
            OP_LTU:     next_result = {31'd0, (A < B)};
            OP_SUMSIGN: next_result = {31'd0, sum_ext[31]};
            default: begin
                next_result   = 32'd0;
                next_carry    = 1'b0;
                next_overflow = 1'b0;
            end
        endcase
    end

    // Zero/Negative are registered alongside Result so all outputs change
    // on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result   <= 32'd0;
            Carry    <= 1'b0;
            OverFlow <= 1'b0;
            Zero     <= 1'b1;
            Negative <= 1'b0;
        end else begin
            Result   <= next_result;
            Carry    <= next_carry;
            OverFlow <= next_overflow;
            Zero     <= (next_result == 32'd0);
            Negative <= next_result[31];
        end
    end

endmodule

// File: tb/tb_alu_32bit.sv
// tb/tb_alu_32bit.sv - table-driven scoreboard bench for alu_32bit

module tb_alu_32bit;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic [31:0] Result;
    logic        Carry;
    logic        OverFlow;
    logic        Zero;
    logic        Negative;

    alu_32bit dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Result     (Result),
        .Carry      (Carry),
        .OverFlow   (OverFlow),
        .Zero       (Zero),
        .Negative   (Negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t exp_v;
    vec_t prev_v;

    int n_cmp;
    int n_bad;

    task automatic add(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic c,
                       input logic v, input logic z, input logic n);
        vec_t t;
        t.name = name; t.op = op; t.a = a; t.b = b; t.res = res;
        t.c = c; t.v = v; t.z = z; t.n = n;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] res, input logic c,
                         input logic v, input logic z, input logic n);
        n_cmp++;
        if ({Result, Carry, OverFlow, Zero, Negative} !== {res, c, v, z, n}) begin
            n_bad++;
            $display("FAIL %s: got R=%h C=%b V=%b Z=%b N=%b, want R=%h C=%b V=%b Z=%b N=%b",
                     name, Result, Carry, OverFlow, Zero, Negative, res, c, v, z, n);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        A = 32'd0;
        B = 32'd0;
        ALUControl = 4'd0;

        //   name          op     A             B             Result        C  V  Z  N
        add("add_small",   4'h0, 32'd15,       32'd10,       32'd25,       0, 0, 0, 0);
        add("add_ovf",     4'h0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 1, 0, 1);
        add("add_carry",   4'h0, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 1, 0);
        add("sub_small",   4'h1, 32'd15,       32'd10,       32'd5,        1, 0, 0, 0);
        add("sub_ovf",     4'h1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1, 1, 0, 0);
        add("sub_eq",      4'h1, 32'd10,       32'd10,       32'd0,        1, 0, 1, 0);
        add("sub_borrow",  4'h1, 32'd10,       32'd15,       32'hFFFFFFFB, 0, 0, 0, 1);
        add("sub_zero_b",  4'h1, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1, 0, 0, 1);
        add("and",         4'h2, 32'd15,       32'd10,       32'd10,       0, 0, 0, 0);
        add("and_ones",    4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1);
        add("or",          4'h3, 32'd15,       32'd10,       32'd15,       0, 0, 0, 0);
        add("mul",         4'h4, 32'd5,        32'd3,        32'd15,       0, 0, 0, 0);
        add("mul_wrap",    4'h4, 32'h00010000, 32'h00010000, 32'd0,        0, 0, 1, 0);
        add("mul_lo",      4'h4, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 0, 0, 0, 1);
        add("div",         4'h5, 32'd10,       32'd3,        32'd3,        0, 0, 0, 0);
        add("rem",         4'hA, 32'd10,       32'd3,        32'd1,        0, 0, 0, 0);
        add("div_by0",     4'h5, 32'd7,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 1);
        add("rem_by0",     4'hA, 32'd7,        32'd0,        32'd7,        0, 0, 0, 0);
        add("div_big",     4'h5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 0, 0, 0, 1);
        add("srl",         4'h6, 32'd16,       32'h12345678, 32'd8,        0, 0, 0, 0);
        add("srl_msb",     4'h6, 32'h80000001, 32'd0,        32'h40000000, 0, 0, 0, 0);
        add("sll",         4'h7, 32'd16,       32'h12345678, 32'd32,       0, 0, 0, 0);
        add("sll_msb",     4'h7, 32'hC0000001, 32'd0,        32'h80000002, 0, 0, 0, 1);
        add("ltu_true",    4'h8, 32'd10,       32'd15,       32'd1,        0, 0, 0, 0);
        add("ltu_false",   4'h8, 32'd15,       32'd10,       32'd0,        0, 0, 1, 0);
        add("ltu_uns",     4'h8, 32'd1,        32'h80000000, 32'd1,        0, 0, 0, 0);
        add("sumsign_0",   4'h9, 32'd15,       32'd10,       32'd0,        0, 0, 1, 0);
        add("sumsign_1",   4'h9, 32'h7FFFFFFF, 32'd1,        32'd1,        0, 0, 0, 0);
        add("op_c",        4'hC, 32'd15,       32'd10,       32'd0,        0, 0, 1, 0);
        add("op_f",        4'hF, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 0, 1, 0);
        add("op_b",        4'hB, 32'h80000000, 32'h80000000, 32'd0,        0, 0, 1, 0);
        add("add_after",   4'h0, 32'h80000000, 32'h80000000, 32'd0,        1, 1, 1, 0);

        // Reset state while rst is held.
        #1;
        check("reset_hold", 32'd0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream: a new opcode every cycle. Before each edge the
        // outputs must still hold the previous result (exactly one edge latency).
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            A = vecs[i].a;
            B = vecs[i].b;
            ALUControl = vecs[i].op;
            sb.push_back(vecs[i]);
            #1;
            if (i > 0)
                check({"hold_", prev_v.name}, prev_v.res, prev_v.c, prev_v.v, prev_v.z, prev_v.n);
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            check(exp_v.name, exp_v.res, exp_v.c, exp_v.v, exp_v.z, exp_v.n);
            prev_v = exp_v;
        end

        // Asynchronous reset between edges discards the visible result.
        @(negedge clk);
        A = 32'h7FFFFFFF; B = 32'd1; ALUControl = 4'h0;
        @(posedge clk);
        #1;
        check("pre_rst", 32'h80000000, 0, 1, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'd0, 0, 0, 1, 0);
        // Reset held across an edge keeps reset values.
        @(posedge clk);
        #1;
        check("rst_over_edge", 32'd0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        A = 32'd10; B = 32'd15; ALUControl = 4'h1;
        #1;
        check("rst_release_hold", 32'd0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        check("first_after_rst", 32'hFFFFFFFB, 0, 0, 0, 1);

        // Pulse reset fully between edges, then resume.
        #2;
        rst = 1'b1;
        #1;
        check("pulse_rst", 32'd0, 0, 0, 1, 0);
        rst = 1'b0;
        #1;
        check("pulse_rst_held", 32'd0, 0, 0, 1, 0);
        @(negedge clk);
        A = 32'd5; B = 32'd3; ALUControl = 4'h4;
        @(posedge clk);
        #1;
        check("after_pulse", 32'd15, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
